// File: rtl/fizzbuzz_gen.sv
// fizzbuzz_gen: streams the FizzBuzz sequence 1..LIMIT as ASCII characters,
// one line per value, to a byte-serial transmitter.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    begins a run from IDLE or DONE (ignored while a run is active)
//   pause    holds off new character issue while high
//   tx_busy  transmitter busy; no character is issued while high
//   tx_send  one-cycle strobe, never high in two consecutive cycles
//   tx_char  7-bit ASCII character, held until the next strobe
//   count    current value in BCD, digit 0 in bits [3:0]
//   done     high once the run has printed LIMIT
module fizzbuzz_gen #(
    parameter int DIV_A   = 3,
    parameter int DIV_B   = 5,
    parameter int LIMIT   = 100,
    parameter int NDIGITS = 3,
    parameter int CRLF    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   tx_busy,
    output logic                   tx_send,
    output logic [6:0]             tx_char,
    output logic [4*NDIGITS-1:0]   count,
    output logic                   done
);

    localparam int CW = 4 * NDIGITS;
    localparam int AW = (DIV_A > 1) ? $clog2(DIV_A) : 1;
    localparam int BW = (DIV_B > 1) ? $clog2(DIV_B) : 1;

    function automatic logic [CW-1:0] to_bcd(input int value);
        logic [CW-1:0] r;
        int            v;
        r = '0;
        v = value;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [CW-1:0] LIMIT_BCD = to_bcd(LIMIT);

    typedef enum logic [1:0] {IDLE, NEXT, EMIT, DONE} state_t;
    typedef enum logic [1:0] {LINE_NUM, LINE_FIZZ, LINE_BUZZ, LINE_FB} line_t;

    state_t        state, state_n;
    logic [CW-1:0] count_n;
    logic [AW-1:0] mod_a, mod_a_n;
    logic [BW-1:0] mod_b, mod_b_n;
    logic [3:0]    idx, idx_n;
    logic          send_n;
    logic [6:0]    char_n;

    line_t         kind;
    logic [CW-1:0] count_inc;
    logic [6:0]    cur_char;
    logic          cur_skip;
    logic          cur_last;

    // Line type follows directly from the residues, which stay fixed during EMIT.
    always_comb begin
        kind = LINE_NUM;
        if (mod_a == '0 && mod_b == '0) kind = LINE_FB;
        else if (mod_a == '0)           kind = LINE_FIZZ;
        else if (mod_b == '0)           kind = LINE_BUZZ;
    end

    // Decimal increment with carry ripple across the BCD digits.
    always_comb begin
        logic       carry;
        logic [3:0] d;
        count_inc = count;
        carry     = 1'b1;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            d = count[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = d + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Character at the current index: body (word or digits) then line ending.
    // A digit is skipped when it and every more-significant digit are zero,
    // except for digit 0 which always prints.
    always_comb begin
        int unsigned pos, body_len, p, w;
        logic        nz;
        logic [3:0]  dig;
        cur_char = 7'h0A;
        cur_skip = 1'b0;
        cur_last = 1'b0;
        nz       = 1'b0;
        dig      = 4'd0;
        p        = 0;
        w        = 0;
        pos      = 32'(idx);
        case (kind)
            LINE_FB:             body_len = 8;
            LINE_FIZZ, LINE_BUZZ: body_len = 4;
            default:             body_len = NDIGITS;
        endcase
        if (pos < body_len) begin
            if (kind == LINE_NUM) begin
                p = NDIGITS - 1 - pos;
                for (int unsigned i = 0; i < NDIGITS; i++) begin
                    if (i == p) dig = count[4*i +: 4];
                    if (i >= p && count[4*i +: 4] != 4'd0) nz = 1'b1;
                end
                cur_skip = (p != 0) && !nz;
                cur_char = {3'b011, dig};
            end else begin
                w = (kind == LINE_BUZZ) ? pos + 4 : pos;
                case (w)
                    0:       cur_char = 7'h46;  // F
                    1:       cur_char = 7'h69;  // i
                    4:       cur_char = 7'h42;  // B
                    5:       cur_char = 7'h75;  // u
                    default: cur_char = 7'h7A;  // z
                endcase
            end
        end else if (pos == body_len) begin
            cur_char = (CRLF != 0) ? 7'h0D : 7'h0A;
            cur_last = (CRLF == 0);
        end else begin
            cur_char = 7'h0A;
            cur_last = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        mod_a_n = mod_a;
        mod_b_n = mod_b;
        idx_n   = idx;
        send_n  = 1'b0;
        char_n  = tx_char;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = NEXT;
                    count_n = '0;
                    mod_a_n = '0;
                    mod_b_n = '0;
                end
            end
            NEXT: begin
                if (count == LIMIT_BCD) begin
                    state_n = DONE;
                end else begin
                    count_n = count_inc;
                    mod_a_n = (mod_a == AW'(DIV_A - 1)) ? '0 : mod_a + 1'b1;
                    mod_b_n = (mod_b == BW'(DIV_B - 1)) ? '0 : mod_b + 1'b1;
                    idx_n   = '0;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (cur_skip) begin
                    idx_n = idx + 4'd1;
                end else if (!tx_busy && !pause && !tx_send) begin
                    send_n = 1'b1;
                    char_n = cur_char;
                    idx_n  = idx + 4'd1;
                    if (cur_last) state_n = NEXT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            mod_a   <= '0;
            mod_b   <= '0;
            idx     <= '0;
            tx_send <= 1'b0;
            tx_char <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            mod_a   <= mod_a_n;
            mod_b   <= mod_b_n;
            idx     <= idx_n;
            tx_send <= send_n;
            tx_char <= char_n;
        end
    end

    assign done = (state == DONE);

endmodule

// File: doc/fizzbuzz_gen.md
FIZZBUZZ_GEN -- requirements
Module: fizzbuzz_gen

Interface
REQ-001 SHALL have parameter DIV_A, default 3, first divisor (2..15), word "Fizz".
REQ-002 SHALL have parameter DIV_B, default 5, second divisor (2..15), word "Buzz".
REQ-003 SHALL have parameter LIMIT, default 100, last value printed (1..10^NDIGITS-1).
REQ-004 SHALL have parameter NDIGITS, default 3, BCD digit count (1..4).
REQ-005 SHALL have parameter CRLF, default 1, line ending: 1 = "\r\n", 0 = "\n".
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1, begins a run from IDLE or DONE.
REQ-009 SHALL have port pause, input, 1, blocks new character issue while high.
REQ-010 SHALL have port tx_busy, input, 1, serial transmitter busy.
REQ-011 SHALL have port tx_send, output, 1, one-cycle character strobe.
REQ-012 SHALL have port tx_char, output, 7, ASCII character, valid when tx_send=1.
REQ-013 SHALL have port count, output, 4*NDIGITS, current BCD value, digit 0 in bits [3:0].
REQ-014 SHALL have port done, output, 1, high in DONE.

Function
REQ-015 SHALL implement states IDLE, NEXT, EMIT, DONE.
REQ-016 SHALL go IDLE->NEXT on start=1; ignore start in NEXT/EMIT.
REQ-017 SHALL go DONE->NEXT on start=1, clearing count and both residues first, so the run restarts at 1.
REQ-018 SHALL, in NEXT: if count==LIMIT go to DONE, else increment BCD count with decimal carry, advance residues modA/modB (wrap DIV-1->0), reset character index, and go to EMIT; exactly one cycle.
REQ-019 SHALL select the line in EMIT: both residues 0 -> "FizzBuzz"; modA==0 -> "Fizz"; modB==0 -> "Buzz"; else decimal digits; then the line ending per CRLF.
REQ-020 SHALL print decimal digits most-significant first, suppressing leading zeros only; the least-significant digit is always printed; tx_char = {3'b011, digit}.
REQ-021 SHALL not strobe for suppressed digits; it skips each at one cycle per digit.
REQ-022 SHALL issue a character only when tx_busy=0, pause=0 and tx_send was 0 in the previous cycle; tx_send is never high two consecutive cycles.
REQ-023 SHALL hold tx_char unchanged until the next strobe.
REQ-024 SHALL go EMIT->NEXT in the cycle the final line-ending character is strobed.
REQ-025 SHALL drop no characters when pause or tx_busy is asserted mid-line; output resumes at the next pending character.
REQ-026 SHALL allow at most one strobe per character; no repeats.
REQ-027 SHALL assert the first tx_send no earlier than the second rising edge after the edge that samples start.
REQ-028 SHALL keep done=1 and tx_send=0 in DONE until start or rst.
REQ-029 SHALL size residue counters as ceil(log2(DIV)) bits; a value reaching DIV is illegal.

Reset
REQ-030 SHALL, while rst=1: state=IDLE, tx_send=0, tx_char=0, count=0, residues=0, done=0, character index=0.
REQ-031 SHALL give rst priority over start; rst mid-line aborts the line immediately with no further strobes.

Verification
REQ-032 Defaults, start pulse, tx_busy=0 -> first 7 lines are "1\r\n","2\r\n","Fizz\r\n","4\r\n","Buzz\r\n","Fizz\r\n","7\r\n"; line 15 is "FizzBuzz\r\n".
REQ-033 Defaults, full run -> 100 lines, last "Buzz\r\n"; line 11 is "11\r\n"; done=1, count=0x100, no further tx_send.
REQ-034 Model tx_busy high 10 cycles after each strobe, plus pause toggled randomly -> byte stream identical to REQ-032/033, no back-to-back strobes.
REQ-035 DIV_A=2, DIV_B=7, LIMIT=14, NDIGITS=2, CRLF=0 -> line 7 "Buzz\n", line 9 "9\n", line 14 "FizzBuzz\n"; then done=1.
REQ-036 rst during the 3rd character of line 5 -> tx_send=0 next cycle, count=0, done=0, IDLE; a new start restarts at "1\r\n".
REQ-037 start while done=1 -> rerun identical to the first run from "1\r\n".
